// File: rtl/sram_pkg.sv
// Shared constants and state encoding for the on-chip asynchronous-SRAM responder.
package sram_pkg;
  localparam int SRAM_DATA_W = 16;
  localparam int SRAM_ADDR_W = 18;
  localparam int LANE_W      = 8;
  localparam int LANE_LO     = 0;
  localparam int LANE_HI     = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_WAIT  = 2'd1,
    RD_DRIVE = 2'd2
  } sram_state_e;
endpackage

// File: rtl/sram_byte_array.sv
// Word-addressed storage as two independent byte lanes with a registered read port.
module sram_byte_array
  import sram_pkg::*;
#(
  parameter int    ADDR_W    = 18,
  parameter string INIT_FILE = ""
) (
  input  logic                   clk,
  input  logic                   we_lo,
  input  logic                   we_hi,
  input  logic [ADDR_W-1:0]      waddr,
  input  logic [SRAM_DATA_W-1:0] wdata,
  input  logic                   re,
  input  logic [ADDR_W-1:0]      raddr,
  output logic [SRAM_DATA_W-1:0] rdata
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [LANE_W-1:0] mem_lo [DEPTH];
  logic [LANE_W-1:0] mem_hi [DEPTH];

  always_ff @(posedge clk) begin
    if (we_lo) mem_lo[waddr] <= wdata[LANE_LO +: LANE_W];
    if (we_hi) mem_hi[waddr] <= wdata[LANE_HI +: LANE_W];
  end

  always_ff @(posedge clk) begin
    if (re) rdata <= {mem_hi[raddr], mem_lo[raddr]};
  end
endmodule

// File: rtl/sram_responder.sv
// Emulates a 16-bit asynchronous SRAM behind its pin interface: byte-lane writes,
// wait-stated reads, access counters and a sticky protocol-error flag.
module sram_responder
  import sram_pkg::*;
#(
  parameter int    ADDR_W    = 18,
  parameter int    READ_LAT  = 2,
  parameter string INIT_FILE = ""
) (
  input  logic                        clk,
  input  logic                        rst,
  inout  wire logic [SRAM_DATA_W-1:0] SRAM_DQ,
  input  logic [SRAM_ADDR_W-1:0]      SRAM_ADDR,
  input  logic                        SRAM_UB_EN,
  input  logic                        SRAM_LB_EN,
  input  logic                        SRAM_WE_EN,
  input  logic                        SRAM_CE_EN,
  input  logic                        SRAM_OE_EN,
  output logic [15:0]                 rd_count,
  output logic [15:0]                 wr_count,
  output logic                        proto_err
);
  localparam int CNT_W = (READ_LAT > 2) ? $clog2(READ_LAT - 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((READ_LAT >= 2) ? READ_LAT - 2 : 0);

  // Pin protocol: a write is sampled on every edge with CE and WE low; a read is
  // requested while CE and OE are low with WE high, and data is presented once the
  // address has been held for READ_LAT edges. There is no backpressure.
  logic wr_pin, rd_pin, addr_ok, wr, rd, err;
  logic [ADDR_W-1:0] addr;

  assign wr_pin  = ~SRAM_CE_EN & ~SRAM_WE_EN;
  assign rd_pin  = ~SRAM_CE_EN & SRAM_WE_EN & ~SRAM_OE_EN;
  assign addr_ok = (SRAM_ADDR >> ADDR_W) == '0;
  assign wr      = wr_pin & addr_ok;
  assign rd      = rd_pin & addr_ok;
  assign addr    = SRAM_ADDR[ADDR_W-1:0];
  assign err     = (wr_pin & SRAM_UB_EN & SRAM_LB_EN) | ((wr_pin | rd_pin) & ~addr_ok);

  sram_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d, load_addr;
  logic              load, restart, wr_q;
  logic [SRAM_DATA_W-1:0] dout;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_addr_d = rd_addr_q;
    load      = 1'b0;
    load_addr = addr;
    restart   = 1'b0;
    if (wr || !rd) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: restart = 1'b1;
        RD_WAIT: begin
          if (addr != rd_addr_q) begin
            restart = 1'b1;
          end else if (cnt_q == '0) begin
            load      = 1'b1;
            load_addr = rd_addr_q;
            state_d   = RD_DRIVE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        RD_DRIVE: if (addr != rd_addr_q) restart = 1'b1;
        default: state_d = IDLE;
      endcase
    end
    // A new address always pays the full latency, whichever state it arrives in.
    if (restart) begin
      rd_addr_d = addr;
      if (READ_LAT == 1) begin
        load    = 1'b1;
        state_d = RD_DRIVE;
      end else begin
        cnt_d   = CNT_LOAD;
        state_d = RD_WAIT;
      end
    end
  end

  sram_byte_array #(
    .ADDR_W    (ADDR_W),
    .INIT_FILE (INIT_FILE)
  ) u_array (
    .clk   (clk),
    .we_lo (wr & ~SRAM_LB_EN & ~rst),
    .we_hi (wr & ~SRAM_UB_EN & ~rst),
    .waddr (addr),
    .wdata (SRAM_DQ),
    .re    (load & ~rst),
    .raddr (load_addr),
    .rdata (dout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rd_addr_q <= '0;
      wr_q      <= 1'b0;
      rd_count  <= 16'd0;
      wr_count  <= 16'd0;
      proto_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_addr_q <= rd_addr_d;
      wr_q      <= wr;
      if (wr && !wr_q && wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
      if (load && rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
      if (err) proto_err <= 1'b1;
    end
  end

  // Release follows the pins combinationally so the bus frees in the cycle OE/CE rise.
  logic drive;
  assign drive = (state_q == RD_DRIVE) & rd;
  assign SRAM_DQ[LANE_LO +: LANE_W] = (drive & ~SRAM_LB_EN) ? dout[LANE_LO +: LANE_W] : 8'hzz;
  assign SRAM_DQ[LANE_HI +: LANE_W] = (drive & ~SRAM_UB_EN) ? dout[LANE_HI +: LANE_W] : 8'hzz;
endmodule

// File: tb/tb_sram_responder.sv
// Bench for sram_responder: directed scenarios then random traffic against a word-array model.
module tb_sram_responder;
  localparam int ADDR_W = 10;
  localparam int LAT    = 2;
  localparam logic [3:0] K_DQ = 4'd0, K_RD = 4'd1, K_WR = 4'd2, K_ERR = 4'd3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wire  [15:0] dq;
  logic [15:0] tb_dq;
  logic        tb_oe;
  logic [17:0] sram_addr;
  logic ub_en, lb_en, we_en, ce_en, oe_en;
  logic [15:0] rd_count, wr_count;
  logic proto_err;

  assign dq = tb_oe ? tb_dq : 16'hzzzz;
  for (genvar g = 0; g < 16; g++) begin : g_pu
    pullup (dq[g]);
  end

  sram_responder #(.ADDR_W(ADDR_W), .READ_LAT(LAT), .INIT_FILE("")) dut (
    .clk(clk), .rst(rst), .SRAM_DQ(dq), .SRAM_ADDR(sram_addr),
    .SRAM_UB_EN(ub_en), .SRAM_LB_EN(lb_en), .SRAM_WE_EN(we_en),
    .SRAM_CE_EN(ce_en), .SRAM_OE_EN(oe_en),
    .rd_count(rd_count), .wr_count(wr_count), .proto_err(proto_err)
  );

  // Scoreboard entries: [19:16] = what to compare, [15:0] = required value.
  logic [19:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  logic [15:0] ref_mem [1 << ADDR_W];
  int ref_rd = 0;
  int ref_wr = 0;
  logic ref_err = 1'b0;
  logic [17:0] pool [8];

  initial begin : monitor
    logic [19:0] e;
    logic [15:0] act;
    string nm;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        case (e[19:16])
          K_DQ:    begin act = dq;                 nm = "dq";        end
          K_RD:    begin act = rd_count;           nm = "rd_count";  end
          K_WR:    begin act = wr_count;           nm = "wr_count";  end
          default: begin act = {15'd0, proto_err}; nm = "proto_err"; end
        endcase
        checks++;
        if (act !== e[15:0]) begin
          errors++;
          $display("FAIL %s actual %h required %h at %0t", nm, act, e[15:0], $time);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1, "watchdog");
  end

  function automatic logic in_range(input logic [17:0] a);
    return (a >> ADDR_W) == 18'd0;
  endfunction

  // Undriven lanes read back as the pull-up value.
  function automatic logic [15:0] lanes(input logic [15:0] d, input logic ub, input logic lb);
    return {ub ? 8'hFF : d[15:8], lb ? 8'hFF : d[7:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    ce_en = 1'b1; we_en = 1'b1; oe_en = 1'b1; ub_en = 1'b1; lb_en = 1'b1; tb_oe = 1'b0;
  endtask

  task automatic push_counters();
    exp_q.push_back({K_RD, 16'(ref_rd)});
    exp_q.push_back({K_WR, 16'(ref_wr)});
    exp_q.push_back({K_ERR, 15'd0, ref_err});
  endtask

  task automatic do_write(input logic [17:0] a, input logic [15:0] d,
                          input logic ub, input logic lb, input int n);
    sram_addr = a; tb_dq = d; tb_oe = 1'b1;
    ce_en = 1'b0; we_en = 1'b0; oe_en = 1'b1; ub_en = ub; lb_en = lb;
    repeat (n) tick();
    bus_idle();
    if (in_range(a)) begin
      ref_wr++;
      if (!lb) ref_mem[a[ADDR_W-1:0]][7:0]  = d[7:0];
      if (!ub) ref_mem[a[ADDR_W-1:0]][15:8] = d[15:8];
      if (ub && lb) ref_err = 1'b1;
    end else begin
      ref_err = 1'b1;
    end
    push_counters();
    tick();
  endtask

  // Holds the read for n sampling edges, then releases the pins in the following cycle.
  task automatic do_read(input logic [17:0] a, input logic ub, input logic lb, input int n);
    logic ok;
    ok = in_range(a);
    sram_addr = a; tb_oe = 1'b0;
    ce_en = 1'b0; we_en = 1'b1; oe_en = 1'b0; ub_en = ub; lb_en = lb;
    exp_q.push_back({K_DQ, 16'hFFFF});
    for (int k = 1; k <= n; k++) begin
      tick();
      if (k < n) begin
        exp_q.push_back({K_DQ, (ok && k >= LAT) ? lanes(ref_mem[a[ADDR_W-1:0]], ub, lb) : 16'hFFFF});
      end else begin
        bus_idle();
        exp_q.push_back({K_DQ, 16'hFFFF});
      end
    end
    if (!ok) ref_err = 1'b1;
    else if (n >= LAT) ref_rd++;
    push_counters();
    tick();
  endtask

  initial begin : stimulus
    int op;
    logic [17:0] a;
    bus_idle();
    sram_addr = '0; tb_dq = '0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    exp_q.push_back({K_DQ, 16'hFFFF});
    push_counters();
    tick();

    do_write(18'h00010, 16'hBEEF, 1'b0, 1'b0, 3);
    do_read(18'h00010, 1'b0, 1'b0, 3);
    do_write(18'h00010, 16'h1234, 1'b1, 1'b0, 1);
    do_read(18'h00010, 1'b0, 1'b0, 3);
    do_read(18'h00010, 1'b1, 1'b0, 4);

    // Address moves after one edge in the wait state: full latency from the change.
    do_write(18'h00020, 16'h5A3C, 1'b0, 1'b0, 1);
    sram_addr = 18'h00010; ce_en = 1'b0; we_en = 1'b1; oe_en = 1'b0; ub_en = 1'b0; lb_en = 1'b0;
    exp_q.push_back({K_DQ, 16'hFFFF});
    tick(); sram_addr = 18'h00020; exp_q.push_back({K_DQ, 16'hFFFF});
    tick(); exp_q.push_back({K_DQ, 16'hFFFF});
    tick(); exp_q.push_back({K_DQ, 16'h5A3C});
    tick(); bus_idle(); exp_q.push_back({K_DQ, 16'hFFFF});
    ref_rd++;
    push_counters();
    tick();

    do_write(18'h00010, 16'h0000, 1'b1, 1'b1, 1);
    do_read(18'h00010, 1'b0, 1'b0, 3);
    do_read(18'h00020, 1'b0, 1'b0, 2);

    // Reset while the bus is being driven.
    sram_addr = 18'h00010; ce_en = 1'b0; we_en = 1'b1; oe_en = 1'b0; ub_en = 1'b0; lb_en = 1'b0;
    exp_q.push_back({K_DQ, 16'hFFFF});
    tick(); exp_q.push_back({K_DQ, 16'hFFFF});
    tick(); rst = 1'b1; exp_q.push_back({K_DQ, 16'hBE34});
    tick();
    ref_rd = 0; ref_wr = 0; ref_err = 1'b0;
    exp_q.push_back({K_DQ, 16'hFFFF});
    push_counters();
    tick(); rst = 1'b0; bus_idle();
    tick();
    do_read(18'h00010, 1'b0, 1'b0, 3);

    // Out-of-range accesses are ignored and flag an error.
    do_write(18'h00410, 16'h0000, 1'b0, 1'b0, 1);
    do_read(18'h20010, 1'b0, 1'b0, 3);
    do_read(18'h00010, 1'b0, 1'b0, 3);

    for (int i = 0; i < 8; i++) begin
      pool[i] = 18'($urandom_range(0, (1 << ADDR_W) - 1));
      do_write(pool[i], 16'($urandom), 1'b0, 1'b0, 1);
    end
    for (int i = 0; i < 40; i++) begin
      op = int'($urandom_range(0, 9));
      a  = pool[$urandom_range(0, 7)];
      if (op == 0 || op == 9) a = a | 18'(18'h400 << $urandom_range(0, 7));
      if (op < 5)
        do_write(a, 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 int'($urandom_range(1, 3)));
      else
        do_read(a, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                int'($urandom_range(1, 4)));
    end

    tick(); tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain actual %0d required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
